// File: rtl/btn_cmd_repeat.sv
// Button command generator: converts debounced levels into single-cycle command
// pulses, with an optional hold-to-repeat (auto-increment) mode per channel.
// One shared tick prescaler feeds an independent 3-state FSM per channel.
module btn_cmd_repeat #(
  parameter int unsigned N           = 9,
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned DELAY_TICKS = 500,
  parameter int unsigned RATE_TICKS  = 100,
  parameter logic [N-1:0] REPEAT_MASK = 9'b000000011,
  parameter int unsigned CNT_W       = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] btn,
  output logic [N-1:0] pulse,
  output logic [N-1:0] held,
  output logic [N-1:0] repeating
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StRepeat
  } state_e;

  logic [PW-1:0]    presc_q;
  logic             tick;
  logic [N-1:0]     btn_prev_q;
  logic [N-1:0]     rise;
  state_e           state_q [N];
  logic [CNT_W-1:0] cnt_q   [N];
  logic [N-1:0]     pulse_q;
  logic [N-1:0]     held_q;
  logic [N-1:0]     rep_q;

  assign tick = (presc_q == PW'(TICK_DIV - 1));
  assign rise = btn & ~btn_prev_q;

  // Free-running prescaler; wraps after TICK_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Previous button level; resets high so a button held through reset stays silent.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_prev_q <= '1;
    end else begin
      btn_prev_q <= btn;
    end
  end

  // Per-channel press/hold/repeat FSMs with registered pulse/held/repeating outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
      pulse_q <= '0;
      held_q  <= '0;
      rep_q   <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        pulse_q[i] <= 1'b0;
        unique case (state_q[i])
          StIdle: begin
            held_q[i] <= rise[i];
            rep_q[i]  <= 1'b0;
            if (rise[i]) begin
              pulse_q[i] <= 1'b1;
              cnt_q[i]   <= '0;
              state_q[i] <= StHold;
            end
          end
          StHold: begin
            // Release takes priority over a maturing tick.
            if (!btn[i]) begin
              state_q[i] <= StIdle;
              cnt_q[i]   <= '0;
              held_q[i]  <= 1'b0;
              rep_q[i]   <= 1'b0;
            end else begin
              held_q[i] <= 1'b1;
              rep_q[i]  <= 1'b0;
              if (tick && REPEAT_MASK[i]) begin
                if (cnt_q[i] == CNT_W'(DELAY_TICKS - 1)) begin
                  pulse_q[i] <= 1'b1;
                  cnt_q[i]   <= '0;
                  state_q[i] <= StRepeat;
                  rep_q[i]   <= 1'b1;
                end else begin
                  cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
              end
            end
          end
          StRepeat: begin
            if (!btn[i]) begin
              state_q[i] <= StIdle;
              cnt_q[i]   <= '0;
              held_q[i]  <= 1'b0;
              rep_q[i]   <= 1'b0;
            end else begin
              held_q[i] <= 1'b1;
              rep_q[i]  <= 1'b1;
              if (tick) begin
                if (cnt_q[i] == CNT_W'(RATE_TICKS - 1)) begin
                  pulse_q[i] <= 1'b1;
                  cnt_q[i]   <= '0;
                end else begin
                  cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
              end
            end
          end
          default: begin
            state_q[i] <= StIdle;
            cnt_q[i]   <= '0;
            held_q[i]  <= 1'b0;
            rep_q[i]   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pulse     = pulse_q;
  assign held      = held_q;
  assign repeating = rep_q;

endmodule

// File: doc/btn_cmd_repeat.md
Name: btn_cmd_repeat

Overview:
- Consumes the debounced button/switch levels from the input-conditioning stage on the Nexys 3.
- Converts each level into single-cycle command pulses for the clock/date/chrono control FSMs.
- Edge-triggered first pulse; optional hold-to-repeat (auto-increment) per channel.
- One shared tick prescaler; one independent 3-state FSM per channel.

Parameters:
- N, 9, number of button channels.
- TICK_DIV, 100000, clk cycles per timing tick (1 ms at 100 MHz); must be >= 2.
- DELAY_TICKS, 500, ticks held before the first repeat pulse; must be >= 1.
- RATE_TICKS, 100, ticks between later repeat pulses; must be >= 1.
- REPEAT_MASK, 9'b000000011, per-channel repeat enable (bit0 aumentar, bit1 disminuir).
- CNT_W, 10, width of per-channel tick counter; must hold max(DELAY_TICKS, RATE_TICKS).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- btn  in  N  debounced levels, 1 = pressed; already synchronous to clk.
- pulse  out  N  registered one-cycle command strobes.
- held  out  N  registered; 1 while channel is in HOLD or REPEAT.
- repeating  out  N  registered; 1 while channel is in REPEAT.

Behaviour:
- Reset (sync, highest priority):
  - pulse, held, repeating = 0; all FSMs in IDLE.
  - Prescaler and tick counters = 0.
  - btn_prev register = all ones, so a button held through reset does not fire. It must be released, then pressed again.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for one cycle when count == TICK_DIV-1.
  - First tick occurs TICK_DIV cycles after reset deasserts.
  - Free-running; not restarted by button activity.
- btn_prev[i] samples btn[i] every cycle.
- rise[i] = btn[i] & ~btn_prev[i].
- Per-channel FSM, evaluated on each clk edge:
  - IDLE:
    - rise[i] -> pulse[i]=1, cnt=0, go HOLD.
    - Otherwise stay.
  - HOLD:
    - btn[i]==0 -> go IDLE, cnt=0, no pulse. Release beats tick.
    - Else if tick and REPEAT_MASK[i]:
      - cnt==DELAY_TICKS-1 -> pulse[i]=1, cnt=0, go REPEAT.
      - Else cnt++.
    - Non-repeat channels stay in HOLD until release; cnt is frozen at 0.
  - REPEAT:
    - btn[i]==0 -> go IDLE, cnt=0.
    - Else if tick: cnt==RATE_TICKS-1 -> pulse[i]=1, cnt=0; else cnt++.
- Latency: btn sampled high at edge k (btn_prev low) -> pulse high in the cycle after edge k, for exactly one cycle.
- Tick counting: ticks are counted only once the registered state is HOLD/REPEAT. A tick coinciding with the rising edge is not counted.
- First repeat timing: arrives (DELAY_TICKS-1)*TICK_DIV+1 to DELAY_TICKS*TICK_DIV cycles after the first pulse, depending on prescaler phase.
- Later repeat spacing: exactly RATE_TICKS*TICK_DIV cycles apart.
- pulse is 0 in every cycle not listed above; never high two consecutive cycles for the same channel.
- Simultaneous events:
  - Channels are fully independent; several pulse bits may be high in the same cycle. No arbitration.
  - Release and the repeat-firing tick in the same cycle: no pulse, go IDLE.
- Glitch handling:
  - A 1-cycle low on btn while in HOLD/REPEAT returns to IDLE.
  - The following high produces a new first pulse and restarts delay timing.
- Reset mid-hold:
  - Outputs clear next edge.
  - Channel stays silent until btn is seen low, then high.
- held[i] and repeating[i] reflect the next state, registered alongside pulse.

Test Plan (TICK_DIV=4, DELAY_TICKS=3, RATE_TICKS=2, N=9, REPEAT_MASK=9'b000000011):
- Single press: btn[4] low->high for 3 cycles, then low -> exactly one pulse[4], 1 cycle after the rise; held[4] high for 3 cycles; repeating[4] never high.
- Hold-repeat: btn[0] held high 40 cycles ->
  - First pulse 1 cycle after the rise.
  - Second pulse 9..12 cycles later.
  - Later pulses exactly every 8 cycles.
  - repeating[0] set from the second pulse onward.
  - All clear 1 cycle after release.
- Non-repeat hold: btn[5] held 40 cycles -> exactly one pulse[5]; held[5]=1 throughout, repeating[5]=0.
- Simultaneous: btn[0] and btn[1] rise in the same cycle -> pulse[0] and pulse[1] both high in the same cycle; their repeat pulses also coincide.
- Reset with button held:
  - btn[0] high before and during reset; reset released -> no pulse while held.
  - Drop btn[0] for 1 cycle, raise again -> one pulse 1 cycle after the rise.
- Release on firing tick: release btn[1] in the exact cycle the repeat tick matures -> no pulse that cycle; state IDLE; held[1]=0 next cycle.
